// File: rtl/lsu_arb.sv
// lsu_arb: two-requester arbiter and sequencer in front of the single-port lsu.
// Every access runs grant -> lsu access -> response; load data is registered.
// Build option: define LSU_ARB_RR_EN for round-robin, else fixed priority (req 0).
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_i, we_i           per-requester request and store/load select
//   addr0_i/addr1_i       requester addresses
//   wdata0_i/wdata1_i     requester store data
//   gnt_o                 one-hot accept pulse (combinational)
//   ack_o, rdata_o        one-hot completion pulse, registered load data
//   busy_o                sequencer not idle
//   lsu_*                 single-port lsu interface
module lsu_arb #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] lsu_addr_o,
    output logic [DATA_W-1:0] lsu_st_data_o,
    output logic              lsu_st_en_o,
    input  logic [DATA_W-1:0] lsu_ld_data_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              accept;
    logic              winner;

    // Gated by reset so no grant escapes while rst_i is held.
    assign accept = !rst_i && (req_i != 2'b00) &&
                    (state_q == IDLE || state_q == RESP);

`ifdef LSU_ARB_RR_EN
    logic rr_q, rr_d;

    // A lone request wins outright; a tie goes to the pointer.
    always_comb begin
        winner = (req_i == 2'b11) ? rr_q : req_i[1];
    end

    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            rr_d = ~winner;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Requester 1 wins only when requester 0 is not asking.
    always_comb begin
        winner = ~req_i[0];
    end
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        gnt_o   = 2'b00;
        unique case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    gnt_o   = winner ? 2'b10 : 2'b01;
                    sel_d   = winner;
                    we_d    = winner ? we_i[1] : we_i[0];
                    addr_d  = winner ? addr1_i : addr0_i;
                    wdata_d = winner ? wdata1_i : wdata0_i;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = lsu_ld_data_i;
                end
                state_d = RESP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Store enable depends only on registered state, so reset kills it at once.
    assign lsu_st_en_o   = (state_q == ACCESS) && we_q;
    assign lsu_addr_o    = addr_q;
    assign lsu_st_data_o = wdata_q;
    assign ack_o         = (state_q != RESP) ? 2'b00 :
                           (sel_q ? 2'b10 : 2'b01);
    assign rdata_o       = rdata_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_lsu_arb.sv
// tb_lsu_arb: vector table plus scoreboard bench for lsu_arb.
// Includes a behavioural single-port lsu (sync store, comb load).
module tb_lsu_arb;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [11:0] a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  gnt, ack;
    logic [31:0] rdata;
    logic        busy;
    logic [11:0] lsu_addr;
    logic [31:0] lsu_st_data;
    logic        lsu_st_en;
    logic [31:0] lsu_ld_data;

    lsu_arb #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .we_i          (we),
        .addr0_i       (a0),
        .addr1_i       (a1),
        .wdata0_i      (d0),
        .wdata1_i      (d1),
        .gnt_o         (gnt),
        .ack_o         (ack),
        .rdata_o       (rdata),
        .busy_o        (busy),
        .lsu_addr_o    (lsu_addr),
        .lsu_st_data_o (lsu_st_data),
        .lsu_st_en_o   (lsu_st_en),
        .lsu_ld_data_i (lsu_ld_data)
    );

    logic [31:0] mem [4096];
    logic [31:0] ref_mem [4096];

    always @(posedge clk) begin
        if (lsu_st_en) mem[lsu_addr] <= lsu_st_data;
    end
    assign lsu_ld_data = mem[lsu_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic        port;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
    } ent_t;

    ent_t        sbq[$];
    logic [31:0] last_rd = 32'h0;

    // Scoreboard monitor: every grant is queued, then its lsu access
    // (one cycle later) and its ack/rdata (two cycles later) are checked.
    always @(negedge clk) begin
        ent_t e;
        logic exp_en;
        if (rst) begin
            sbq.delete();
            last_rd = 32'h0;
        end
        exp_en = 1'b0;
        if (sbq.size() > 0 && sbq[$].cyc + 1 == cyc) begin
            e = sbq[$];
            exp_en = e.we;
            chk("lsu_addr", {20'h0, lsu_addr}, {20'h0, e.addr});
            if (e.we) chk("lsu_st_data", lsu_st_data, e.wdata);
        end
        chk("lsu_st_en", {31'h0, lsu_st_en}, {31'h0, exp_en});
        if (sbq.size() > 0 && sbq[0].cyc + 2 == cyc) begin
            e = sbq.pop_front();
            chk("ack", {30'h0, ack}, {30'h0, (e.port ? 2'b10 : 2'b01)});
            if (e.we) begin
                chk("rdata_hold", rdata, last_rd);
                ref_mem[e.addr] = e.wdata;
            end else begin
                chk("rdata", rdata, ref_mem[e.addr]);
                last_rd = ref_mem[e.addr];
            end
        end else begin
            chk("ack_idle", {30'h0, ack}, 32'h0);
        end
        if (gnt != 2'b00) begin
            e.cyc   = cyc;
            e.port  = gnt[1];
            e.we    = gnt[1] ? we[1] : we[0];
            e.addr  = gnt[1] ? a1 : a0;
            e.wdata = gnt[1] ? d1 : d0;
            sbq.push_back(e);
        end
    end

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [11:0] a0;
        logic [11:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  gnt;
    } vec_t;

`ifdef LSU_ARB_RR_EN
    localparam logic [1:0] G_TIE1 = 2'b10;
    localparam bit         RR     = 1'b1;
`else
    localparam logic [1:0] G_TIE1 = 2'b01;
    localparam bit         RR     = 1'b0;
`endif

    vec_t tv[10];

    task automatic drive(input vec_t v);
        req = v.req;
        we  = v.we;
        a0  = v.a0;
        a1  = v.a1;
        d0  = v.d0;
        d1  = v.d1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] eg;
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        tv[0] = '{2'b01, 2'b01, 12'h001, 12'h000, 32'hDEADBEEF, 32'h0, 2'b01};
        tv[1] = '{2'b10, 2'b00, 12'h000, 12'h001, 32'h0, 32'h0, 2'b10};
        tv[2] = '{2'b10, 2'b10, 12'h000, 12'h0FF, 32'h0, 32'h12345678, 2'b10};
        tv[3] = '{2'b01, 2'b00, 12'h0FF, 12'h000, 32'h0, 32'h0, 2'b01};
        tv[4] = '{2'b11, 2'b11, 12'h002, 12'h003, 32'hA5A5A5A5, 32'h5A5A5A5A,
                  G_TIE1};
        tv[5] = '{2'b11, 2'b00, 12'h002, 12'h003, 32'h0, 32'h0, 2'b01};
        tv[6] = '{2'b10, 2'b00, 12'h000, 12'hFFF, 32'h0, 32'h0, 2'b10};
        tv[7] = '{2'b01, 2'b01, 12'hFFF, 12'h000, 32'hFFFFFFFF, 32'h0, 2'b01};
        tv[8] = '{2'b10, 2'b00, 12'h000, 12'hFFF, 32'h0, 32'h0, 2'b10};
        tv[9] = '{2'b00, 2'b11, 12'h123, 12'h456, 32'h1, 32'h2, 2'b00};

        // Reset with both requesting: everything must stay at zero.
        rst = 1'b1;
        req = 2'b11;
        we  = 2'b11;
        a0  = 12'hABC;
        a1  = 12'hDEF;
        d0  = 32'h11111111;
        d1  = 32'h22222222;
        repeat (2) @(negedge clk);
        chk("rst_gnt", {30'h0, gnt}, 32'h0);
        chk("rst_ack", {30'h0, ack}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_st_en", {31'h0, lsu_st_en}, 32'h0);
        chk("rst_addr", {20'h0, lsu_addr}, 32'h0);
        chk("rst_st_data", lsu_st_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 2'b00;

        // Single transactions from the table.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            drive(tv[i]);
            @(negedge clk);
            chk($sformatf("tv%0d_gnt", i), {30'h0, gnt}, {30'h0, tv[i].gnt});
            @(posedge clk);
            #1;
            req = 2'b00;
            repeat (2) @(posedge clk);
        end

        // Both requesters held continuously for eight cycles.
        @(posedge clk);
        #1;
        req = 2'b11;
        we  = 2'b00;
        a0  = 12'h002;
        a1  = 12'h003;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k % 2 == 1) eg = 2'b00;
            else if (RR && ((k / 2) % 2 == 1)) eg = 2'b10;
            else eg = 2'b01;
            chk($sformatf("tie_gnt%0d", k), {30'h0, gnt}, {30'h0, eg});
            @(posedge clk);
            #1;
        end
        req = 2'b00;
        repeat (3) @(posedge clk);

        // Back-to-back: new request lands in the RESP cycle.
        #1;
        req = 2'b01;
        we  = 2'b01;
        a0  = 12'h020;
        d0  = 32'hCAFEF00D;
        @(negedge clk);
        chk("b2b_gnt0", {30'h0, gnt}, 32'h1);
        @(posedge clk);
        #1;
        req = 2'b00;
        @(posedge clk);
        #1;
        req = 2'b10;
        we  = 2'b00;
        a1  = 12'h020;
        @(negedge clk);
        chk("b2b_gnt1", {30'h0, gnt}, 32'h2);
        chk("b2b_busy_resp", {31'h0, busy}, 32'h1);
        @(posedge clk);
        #1;
        req = 2'b00;
        @(negedge clk);
        chk("b2b_busy_acc", {31'h0, busy}, 32'h1);
        repeat (3) @(posedge clk);

        // Reset in the middle of a store access.
        #1;
        req = 2'b01;
        we  = 2'b01;
        a0  = 12'h010;
        d0  = 32'hFFFF0000;
        @(negedge clk);
        chk("rst_acc_gnt", {30'h0, gnt}, 32'h1);
        @(posedge clk);
        #1;
        req = 2'b00;
        #1;
        chk("pre_rst_st_en", {31'h0, lsu_st_en}, 32'h1);
        rst = 1'b1;
        #1;
        chk("async_st_en", {31'h0, lsu_st_en}, 32'h0);
        chk("async_busy", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ack", {30'h0, ack}, 32'h0);
        @(posedge clk);
        #1;
        req = 2'b10;
        we  = 2'b00;
        a1  = 12'h010;
        @(negedge clk);
        chk("post_rst_gnt", {30'h0, gnt}, 32'h2);
        @(posedge clk);
        #1;
        req = 2'b00;
        repeat (3) @(posedge clk);
        chk("aborted_store_mem", mem[12'h010], 32'h0);
        chk("sb_drained", sbq.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
